led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Sequencer for the 4-LED bank. Prescales clk into a step tick and steps a
//  4-bit pattern through one of four modes, with run/pause/single-step control.
//  Applies PWM brightness to the pattern before driving led_out.
//  Replaces the free-running counter taps that currently drive the board LEDs.
// PARAMETERS
//  TICK_DIV  6_250_000  clk cycles per pattern step (8 steps/s @ 50 MHz); >=2
//  DIV_W     23         prescaler width; 2**DIV_W >= TICK_DIV
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  synchronous, active-high
//  mode       in   2  00 count, 01 chase, 10 bounce, 11 blink
//  run        in   1  level: 1 = step on ticks, 0 = pause
//  step_req   in   1  1-cycle pulse: single step while paused
//  bright     in   4  PWM duty: 0 = off, 15 = fully on
//  led_out    out  4  gated pattern to LEDs
//  step_tick  out  1  1-cycle pulse on each pattern advance
//  running    out  1  1 while FSM is in RUN
// BEHAVIOUR
//  Reset: state=IDLE, pat=0000, dir=up, prescaler=0, pwm_cnt=0, mode_q=mode.
//   Reset value of every output is 0. Reset overrides all inputs.
//  FSM: IDLE -run-> RUN; RUN -!run-> PAUSE; PAUSE -run-> RUN. IDLE is left
//   only by run=1 and is re-entered only via reset.
//  IDLE: led_out forced 0. mode_q tracks mode. pat held at init(mode).
//  Init values: 00->0000, 01->0001, 10->0001 with dir=up, 11->0000.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
//   It is held in PAUSE and cleared on entry to RUN from IDLE.
//  Advance: occurs when prescaler==TICK_DIV-1 in RUN, or when step_req=1 in
//   PAUSE. On an advance, pat updates on the next edge and step_tick=1 that
//   cycle. step_req is ignored in IDLE and RUN.
//  Pattern rules:
//   00  pat+1 mod 16 (F->0)
//   01  rotate left (1000->0001)
//   10  shift in dir; at 1000 dir->down, at 0001 dir->up
//       sequence 1,2,4,8,4,2,1,2
//   11  toggle 0000<->1111
//  Mode change (mode!=mode_q, RUN/PAUSE): next edge loads pat=init(mode) and
//   dir=up, clears the prescaler, and sets mode_q=mode. It wins over a
//   same-cycle advance (no step_tick). If pat holds a value not legal for the
//   new mode, that value is still replaced by init.
//  PWM: pwm_cnt is a free-running 4-bit counter from reset.
//   en = (bright==15) | (pwm_cnt<bright).
//   led_out register = (state!=IDLE) ? pat & {4{en}} : 0, i.e. one cycle after
//   pat/pwm_cnt. bright is sampled every cycle with no glitch protection.
//  run toggling on the tick cycle: the FSM transition and the advance use
//   the same sampled values. A tick in RUN with run=0 still advances that
//   cycle, then the FSM enters PAUSE.
// TESTING (TICK_DIV=4, bright=15 unless noted)
//  1 reset, mode=00, run=1 -> led_out 1,2,..,F,0 changes every 4 cycles.
//    step_tick is pulsed once per change.
//  2 mode=10, run=1 -> led_out 1,2,4,8,4,2,1,2.
//    Reassert reset mid-sequence -> led_out=0 and running=0 the next cycle.
//  3 mode=01, run=1 then 0 -> led_out frozen, no step_tick. step_req pulse ->
//    exactly one rotate, e.g. 0100->1000. step_req while run=1 is ignored.
//  4 mode 00->11 on the same cycle as a tick -> pat=0000, no step_tick,
//    then 1111 after 4 cycles.
//  5 mode=11 at pat=1111: bright=4 -> led_out=F for 4 of every 16 cycles;
//    bright=0 -> always 0; bright=15 -> always F.
//  6 run=0 after reset -> led_out stays 0 and step_req is ignored (IDLE).

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern sequencer: prescaled step tick, four pattern modes,
// run/pause/single-step control and PWM brightness gating of the output.
module led_pattern_ctrl #(
    parameter int unsigned TICK_DIV = 6_250_000,
    parameter int unsigned DIV_W    = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       run,
    input  logic       step_req,
    input  logic [3:0] bright,
    output logic [3:0] led_out,
    output logic       step_tick,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    state_t           state;
    logic [3:0]       pat;
    logic [3:0]       pwm_cnt;
    logic             dir_up;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] presc;

    logic [3:0] next_pat_c;
    logic       next_dir_c;
    logic       advance_c;
    logic       mode_chg_c;
    logic       pwm_en_c;

    function automatic logic [3:0] init_of(input logic [1:0] m);
        return (m == 2'b01 || m == 2'b10) ? 4'b0001 : 4'b0000;
    endfunction

    // Next pattern for the latched mode; bounce turns around at the ends.
    always_comb begin
        next_pat_c = pat;
        next_dir_c = dir_up;
        case (mode_q)
            2'b00: next_pat_c = pat + 4'd1;
            2'b01: next_pat_c = {pat[2:0], pat[3]};
            2'b10: begin
                if (pat == 4'b1000)      next_dir_c = 1'b0;
                else if (pat == 4'b0001) next_dir_c = 1'b1;
                next_pat_c = next_dir_c ? {pat[2:0], 1'b0} : {1'b0, pat[3:1]};
            end
            default: next_pat_c = ~pat;
        endcase
    end

    always_comb begin
        advance_c  = ((state == RUN) && (presc == TICK_LAST)) ||
                     ((state == PAUSE) && step_req);
        mode_chg_c = (mode != mode_q);
        pwm_en_c   = (bright == 4'hF) || (pwm_cnt < bright);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pat       <= 4'b0000;
            dir_up    <= 1'b1;
            presc     <= '0;
            pwm_cnt   <= 4'd0;
            mode_q    <= mode;
            led_out   <= 4'b0000;
            step_tick <= 1'b0;
            running   <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 4'd1;
            step_tick <= 1'b0;
            led_out   <= (state != IDLE) ? (pat & {4{pwm_en_c}}) : 4'b0000;
            case (state)
                IDLE: begin
                    pat    <= init_of(mode);
                    dir_up <= 1'b1;
                    mode_q <= mode;
                    if (run) begin
                        state   <= RUN;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                end
                RUN, PAUSE: begin
                    // A mode change restarts the pattern and beats any advance.
                    if (mode_chg_c) begin
                        pat    <= init_of(mode);
                        dir_up <= 1'b1;
                        presc  <= '0;
                        mode_q <= mode;
                    end else begin
                        if (advance_c) begin
                            pat       <= next_pat_c;
                            dir_up    <= next_dir_c;
                            step_tick <= 1'b1;
                        end
                        if (state == RUN)
                            presc <= (presc == TICK_LAST) ? '0 : presc + DIV_W'(1);
                    end
                    if (state == RUN && !run) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (state == PAUSE && run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: the driver pushes the expected
// per-cycle outputs from an abstract model, a monitor pops and compares.
module tb_led_pattern_ctrl;

    localparam int unsigned TD = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] mode     = 2'b00;
    logic       run      = 1'b0;
    logic       step_req = 1'b0;
    logic [3:0] bright   = 4'hF;
    logic [3:0] led_out;
    logic       step_tick;
    logic       running;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .run       (run),
        .step_req  (step_req),
        .bright    (bright),
        .led_out   (led_out),
        .step_tick (step_tick),
        .running   (running)
    );

    typedef struct packed {
        logic [3:0] led;
        logic       tick;
        logic       run;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Model: state 0 idle / 1 run / 2 pause; pattern = f(mode, steps since init)
    int         m_st    = 0;
    logic [1:0] m_mq    = 2'b00;
    int         m_k     = 0;
    int         m_presc = 0;
    int         m_pwm   = 0;
    logic [3:0] bseq [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};

    function automatic logic [3:0] pat_of(input logic [1:0] m, input int k);
        case (m)
            2'b00:   return 4'(k % 16);
            2'b01:   return 4'(1 << (k % 4));
            2'b10:   return bseq[k % 6];
            default: return (k % 2 == 1) ? 4'hF : 4'h0;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic [1:0] md, input logic rn,
                       input logic sr, input logic [3:0] br);
        exp_t e;
        bit   en;
        bit   adv;
        @(negedge clk);
        reset = r; mode = md; run = rn; step_req = sr; bright = br;
        e = '0;
        if (r) begin
            m_st = 0; m_k = 0; m_presc = 0; m_pwm = 0; m_mq = md;
        end else begin
            en    = (br == 4'hF) || (m_pwm < int'(br));
            e.led = (m_st != 0 && en) ? pat_of(m_mq, m_k) : 4'h0;
            m_pwm = (m_pwm + 1) % 16;
            if (m_st == 0) begin
                m_mq = md;
                m_k  = 0;
                if (rn) begin m_st = 1; m_presc = 0; end
            end else begin
                if (md != m_mq) begin
                    m_mq = md; m_k = 0; m_presc = 0;
                end else begin
                    adv = (m_st == 1 && m_presc == int'(TD) - 1) || (m_st == 2 && sr);
                    if (adv) begin m_k++; e.tick = 1'b1; end
                    if (m_st == 1) m_presc = (m_presc + 1) % int'(TD);
                end
                if (m_st == 1 && !rn)      m_st = 2;
                else if (m_st == 2 && rn)  m_st = 1;
            end
            e.run = (m_st == 1);
        end
        sbq.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (led_out !== e.led) begin
                    errors++;
                    $display("FAIL led_out t=%0t got %h exp %h", $time, led_out, e.led);
                end
                checks++;
                if (step_tick !== e.tick) begin
                    errors++;
                    $display("FAIL step_tick t=%0t got %b exp %b", $time, step_tick, e.tick);
                end
                checks++;
                if (running !== e.run) begin
                    errors++;
                    $display("FAIL running t=%0t got %b exp %b", $time, running, e.run);
                end
            end
        end
    end

    initial begin
        logic [1:0] r_mode;
        logic       r_run;
        logic [3:0] r_br;
        logic [3:0] bl [4] = '{4'd4, 4'd0, 4'd15, 4'd9};

        // count mode
        repeat (2) cyc(1'b1, 2'b00, 1'b1, 1'b0, 4'hF);
        repeat (70) cyc(1'b0, 2'b00, 1'b1, 1'b0, 4'hF);

        // bounce, reset mid-sequence
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 4'hF);
        repeat (30) cyc(1'b0, 2'b10, 1'b1, 1'b0, 4'hF);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 4'hF);
        repeat (3) cyc(1'b0, 2'b10, 1'b1, 1'b0, 4'hF);

        // chase with pause, single steps, and step_req while running
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 4'hF);
        repeat (10) cyc(1'b0, 2'b01, 1'b1, 1'b0, 4'hF);
        repeat (8) cyc(1'b0, 2'b01, 1'b0, 1'b0, 4'hF);
        cyc(1'b0, 2'b01, 1'b0, 1'b1, 4'hF);
        repeat (6) cyc(1'b0, 2'b01, 1'b0, 1'b0, 4'hF);
        cyc(1'b0, 2'b01, 1'b0, 1'b1, 4'hF);
        cyc(1'b0, 2'b01, 1'b0, 1'b0, 4'hF);
        repeat (5) cyc(1'b0, 2'b01, 1'b1, 1'b0, 4'hF);
        cyc(1'b0, 2'b01, 1'b1, 1'b1, 4'hF);
        repeat (5) cyc(1'b0, 2'b01, 1'b1, 1'b0, 4'hF);

        // mode 00 -> 11 at each prescaler phase, including the tick cycle
        for (int off = 0; off < 4; off++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0, 4'hF);
            repeat (3 + off) cyc(1'b0, 2'b00, 1'b1, 1'b0, 4'hF);
            repeat (11) cyc(1'b0, 2'b11, 1'b1, 1'b0, 4'hF);
        end

        // blink held at 1111, brightness sweep
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 4'hF);
        repeat (5) cyc(1'b0, 2'b11, 1'b1, 1'b0, 4'hF);
        for (int b = 0; b < 4; b++)
            repeat (32) cyc(1'b0, 2'b11, 1'b0, 1'b0, bl[b]);

        // idle ignores step_req
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 4'hF);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 2'($urandom_range(3)), 1'b0, (i % 3 == 0), 4'hF);

        // randomized traffic
        r_mode = 2'b00; r_run = 1'b1; r_br = 4'hF;
        cyc(1'b1, r_mode, r_run, 1'b0, r_br);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(31) == 0) r_mode = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) r_run  = ~r_run;
            if ($urandom_range(7) == 0)  r_br   = 4'($urandom_range(15));
            cyc(($urandom_range(99) == 0), r_mode, r_run,
                ($urandom_range(3) == 0), r_br);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
